// File: rtl/pc_and_branch_if.sv
// Fetch-stage control bus between the pipeline control (master) and the PC block (slave).
// With PC_STATS_EN defined the bus also carries the branch/jump statistics counters.
interface pc_and_branch_if;
  logic        PC_enable;
  logic        branch;
  logic        jumpAL;
  logic        takeBranch;
  logic [31:0] branch_PC;
  logic [31:0] PC_IFID_in;
  logic [31:0] PC_plus4;
  logic        redirect;
  logic        misaligned;
`ifdef PC_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
  logic [31:0] stat_jumps;
`endif

  modport master (
    output PC_enable,
    output branch,
    output jumpAL,
    output takeBranch,
    output branch_PC,
    input  PC_IFID_in,
    input  PC_plus4,
    input  redirect,
    input  misaligned
`ifdef PC_STATS_EN
    ,
    input  stat_branches,
    input  stat_taken,
    input  stat_jumps
`endif
  );

  modport slave (
    input  PC_enable,
    input  branch,
    input  jumpAL,
    input  takeBranch,
    input  branch_PC,
    output PC_IFID_in,
    output PC_plus4,
    output redirect,
    output misaligned
`ifdef PC_STATS_EN
    ,
    output stat_branches,
    output stat_taken,
    output stat_jumps
`endif
  );
endinterface

// File: rtl/pc_and_branch.sv
// Program counter and next-PC selection for the fetch stage: sequential, stall, or redirect.
// Optional feature macro PC_STATS_EN adds saturating branch/taken/jump counters.
module pc_and_branch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  pc_and_branch_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        misaligned_q, misaligned_d;
  logic        redir;

  always_comb begin
    redir        = bus.takeBranch | bus.jumpAL;
    pc_d         = pc_q;
    redirect_d   = redir;
    misaligned_d = redir & (|bus.branch_PC[1:0]);
    // A flush wins over a stall, so redirect is checked before PC_enable.
    if (redir) begin
      pc_d = {bus.branch_PC[31:2], 2'b00};
    end else if (bus.PC_enable) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      redirect_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.PC_IFID_in = pc_q;
  assign bus.PC_plus4   = pc_q + 32'd4;
  assign bus.redirect   = redirect_q;
  assign bus.misaligned = misaligned_q;

`ifdef PC_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_taken_q, stat_taken_d;
  logic [31:0] stat_jumps_q, stat_jumps_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_taken_d    = stat_taken_q;
    stat_jumps_d    = stat_jumps_q;
    if (bus.branch && (stat_branches_q != 32'hFFFF_FFFF)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (bus.branch && bus.takeBranch && (stat_taken_q != 32'hFFFF_FFFF)) begin
      stat_taken_d = stat_taken_q + 32'd1;
    end
    if (bus.jumpAL && (stat_jumps_q != 32'hFFFF_FFFF)) begin
      stat_jumps_d = stat_jumps_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= 32'd0;
      stat_taken_q    <= 32'd0;
      stat_jumps_q    <= 32'd0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
      stat_jumps_q    <= stat_jumps_d;
    end
  end

  assign bus.stat_branches = stat_branches_q;
  assign bus.stat_taken    = stat_taken_q;
  assign bus.stat_jumps    = stat_jumps_q;
`endif

endmodule

// File: tb/tb_pc_and_branch.sv
// Self-checking bench for pc_and_branch: directed scenarios followed by random stimulus,
// compared against a behavioural PC model.
module tb_pc_and_branch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;

  pc_and_branch_if bus ();

  pc_and_branch #(
    .RESET_PC (ResetPc)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference state
  logic [31:0] m_pc;
  logic        m_redirect;
  logic        m_misaligned;
  longint unsigned m_branches, m_taken, m_jumps;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat32(input longint unsigned v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic step(input logic r, input logic en, input logic br, input logic jal,
                      input logic tk, input logic [31:0] tgt);
    @(negedge clk);
    rst            = r;
    bus.PC_enable  = en;
    bus.branch     = br;
    bus.jumpAL     = jal;
    bus.takeBranch = tk;
    bus.branch_PC  = tgt;
    @(posedge clk);
    if (r) begin
      m_pc = ResetPc;
      m_redirect = 1'b0;
      m_misaligned = 1'b0;
      m_branches = 0;
      m_taken = 0;
      m_jumps = 0;
    end else begin
      m_redirect   = tk || jal;
      m_misaligned = (tk || jal) && (tgt % 4 != 0);
      if (tk || jal) m_pc = tgt - (tgt % 4);
      else if (en)   m_pc = m_pc + 32'd4;
      if (br)        m_branches++;
      if (br && tk)  m_taken++;
      if (jal)       m_jumps++;
    end
    #1;
    check_eq("pc", bus.PC_IFID_in, m_pc);
    check_eq("pc_plus4", bus.PC_plus4, m_pc + 32'd4);
    check_eq("redirect", {31'd0, bus.redirect}, {31'd0, m_redirect});
    check_eq("misaligned", {31'd0, bus.misaligned}, {31'd0, m_misaligned});
`ifdef PC_STATS_EN
    check_eq("stat_branches", bus.stat_branches, sat32(m_branches));
    check_eq("stat_taken", bus.stat_taken, sat32(m_taken));
    check_eq("stat_jumps", bus.stat_jumps, sat32(m_jumps));
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.PC_enable = 1'b0;
    bus.branch = 1'b0;
    bus.jumpAL = 1'b0;
    bus.takeBranch = 1'b0;
    bus.branch_PC = 32'd0;
    m_pc = ResetPc;
    m_redirect = 1'b0;
    m_misaligned = 1'b0;
    m_branches = 0;
    m_taken = 0;
    m_jumps = 0;

    // Reset, then sequential advance
    step(1, 0, 0, 0, 0, 32'h0);
    check_eq("reset_pc_const", bus.PC_IFID_in, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 32'h0);
    check_eq("seq_pc16", bus.PC_IFID_in, 32'h10);

    // Taken branch from PC 8
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 32'h0);
    step(0, 1, 1, 0, 1, 32'h100);
    check_eq("br_target", bus.PC_IFID_in, 32'h100);
    step(0, 1, 0, 0, 0, 32'h0);
    check_eq("br_next", bus.PC_IFID_in, 32'h104);

    // Stall at 0x20, then jump with stall still asserted
    step(0, 0, 0, 1, 0, 32'h20);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'h0);
    check_eq("stall_hold", bus.PC_IFID_in, 32'h20);
    step(0, 0, 0, 1, 0, 32'h40);
    check_eq("flush_beats_stall", bus.PC_IFID_in, 32'h40);

    // Misaligned target, both redirect sources at once
    step(0, 1, 1, 1, 1, 32'h203);
    check_eq("misaligned_pc", bus.PC_IFID_in, 32'h200);
    step(0, 1, 0, 0, 0, 32'h0);

    // Wrap and reset-over-redirect
    step(0, 1, 0, 1, 0, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0, 32'h0);
    check_eq("wrap", bus.PC_IFID_in, 32'h0);
    step(1, 1, 1, 0, 1, 32'h500);

    // Statistics scenario (counters checked inside step when enabled)
    step(0, 1, 1, 0, 0, 32'h0);
    step(0, 1, 1, 0, 1, 32'h80);
    step(0, 1, 1, 0, 0, 32'h0);
    step(0, 1, 0, 1, 0, 32'hC0);

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0),
           $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_and_branch.md
# pc_and_branch

Program-counter register and next-PC selector for the CPU fetch stage. Holds the current fetch address and drives it to the IF/ID pipeline register and the instruction-memory index (`PC_IFID_in >> 2`). Each cycle it advances sequentially by 4, holds for a stall, or redirects to a branch or jump target resolved later in the pipeline.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; must be word-aligned.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `PC_enable` input 1: 1 lets the PC advance sequentially; 0 stalls (holds) the PC.
- `branch` input 1: the redirecting instruction is a conditional branch. Qualifier only.
- `jumpAL` input 1: the redirecting instruction is JAL/JALR. Forces a redirect.
- `takeBranch` input 1: a branch was resolved taken. Forces a redirect.
- `branch_PC` input 32: redirect target address.
- `PC_IFID_in` output 32: registered current PC.
- `PC_plus4` output 32: combinational `PC_IFID_in + 4`, modulo 2^32.
- `redirect` output 1: registered. High for exactly the cycle after a redirect was taken.
- `misaligned` output 1: registered. High for the cycle after a redirect whose `branch_PC[1:0] != 0`.

## Operation

- Redirect condition: `redir = takeBranch | jumpAL`. `branch` alone never changes the PC.
- Next-PC priority, evaluated at each rising edge:
  1. `rst` = 1: PC ← `RESET_PC`; `redirect` ← 0; `misaligned` ← 0.
  2. `redir` = 1: PC ← `{branch_PC[31:2], 2'b00}`. This applies regardless of `PC_enable`, so a flush overrides a stall.
  3. `PC_enable` = 1: PC ← PC + 4. Wraps from `32'hFFFF_FFFC` to `32'h0000_0000`.
  4. Otherwise: PC holds.
- Target alignment: the low two bits of the target are always forced to 0. When a redirect occurs with `branch_PC[1:0] != 0`, `misaligned` pulses for one cycle. No other exception action is taken.
- `redirect` is a one-cycle pulse per redirect cycle. Back-to-back redirects keep it high continuously.
- PC bits [1:0] are always 0.

## Timing

- Latency is 1 cycle from inputs to `PC_IFID_in`. The PC value after edge N reflects inputs sampled at edge N.
- `PC_plus4` is purely combinational from the PC register, with zero latency.
- Reset values: `PC_IFID_in` = `RESET_PC`, `redirect` = 0, `misaligned` = 0. `PC_plus4` = `RESET_PC` + 4.
- Reset asserted mid-operation overrides any simultaneous redirect or enable on that edge.
- When `takeBranch` and `jumpAL` are both high, there is a single redirect to `branch_PC`, no double count.
- There is no handshake: inputs are sampled every edge and must be stable around it.

## Configuration

- `PC_STATS_EN`: when defined, the block adds three 32-bit saturating counters, cleared by `rst`:
  - `stat_branches`: increments on edges with `branch` = 1.
  - `stat_taken`: increments on edges with `branch & takeBranch`.
  - `stat_jumps`: increments on edges with `jumpAL` = 1.
  - The counters are exposed as output ports with those names and saturate at `32'hFFFF_FFFF`.
- When `PC_STATS_EN` is undefined, these ports and registers are absent. PC behaviour is identical in both builds.

## Test plan

- Reset then `PC_enable` = 1 for 4 cycles: PC = 0, 4, 8, 12, 16; `PC_plus4` = PC + 4; `redirect` = 0.
- At PC = 8, `takeBranch` = 1, `branch_PC` = `32'h100` → next PC = `32'h100`, `redirect` = 1 for one cycle. The following cycle PC = `32'h104`.
- `PC_enable` = 0 for 3 cycles at PC = `32'h20` → PC holds at `32'h20`. Then `jumpAL` = 1, `branch_PC` = `32'h40` with `PC_enable` still 0 → PC = `32'h40` (flush beats stall).
- Redirect with `branch_PC` = `32'h203` → PC = `32'h200`, `misaligned` = 1 for one cycle.
- PC at `32'hFFFF_FFFC` with `PC_enable` = 1 → PC = 0. Then `rst` = 1 simultaneous with `takeBranch` = 1 → PC = `RESET_PC`, `redirect` = 0.
- With `PC_STATS_EN` defined: 3 cycles of `branch` = 1 with `takeBranch` = 1 on one of them, plus 1 cycle of `jumpAL` = 1 → `stat_branches` = 3, `stat_taken` = 1, `stat_jumps` = 1.
